// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA layout,
// register-space addresses and a byte-merge helper.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA    = 3'd1,
    ST_LAT   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } hb_state_e;

  localparam int WORD_W = 16;

  // Command/address phase is six DDR bytes, shifted in MSB first.
  localparam int CA_BYTES = 6;
  localparam logic [2:0] CA_LAST = 3'(CA_BYTES - 1);

  // Field positions inside CA byte 0 (CA[47:40]). CA[45] is the burst
  // type and is ignored: bursts are always linear.
  localparam int CA_B0_RW_BIT  = 7;  // CA[47] 1 = read
  localparam int CA_B0_AS_BIT  = 6;  // CA[46] 1 = register space
  localparam int CA_B0_ROW_MSB = 4;  // CA[44] top of the row address
  // Bytes 1..3 carry CA[39:16]; byte 4 is reserved; byte 5 holds the
  // column bits CA[2:0].

  localparam logic [31:0] CR0_ADDR = 32'h0000_0800;
  localparam logic [31:0] ID0_ADDR = 32'h0000_0000;
  localparam int CR0_LAT2X_BIT = 3;

  // Merge a new word into an old one under per-byte enables {hi, lo}.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [1:0]        be
  );
    logic [WORD_W-1:0] res;
    res[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
    res[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
    return res;
  endfunction

endpackage

// File: rtl/hyperbus_resp_mem.sv
// Single-port 16-bit word RAM with two byte enables and a registered read.
// No reset so that it maps onto iCE40 block RAM.
module hyperbus_resp_mem
  import hyperbus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [0:(1<<ADDR_W)-1];

  // Byte-enabled write port.
  always_ff @(posedge clk) begin
    if (we && be[1]) mem_r[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem_r[addr][7:0]  <= wdata[7:0];
  end

  // Registered read, one clk latency.
  always_ff @(posedge clk) begin
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder. dram_ck is sampled as a strobe on clk;
// every toggle carries one DDR byte. Backed by a word RAM plus CR0/ID0.
module hyperbus_responder
  import hyperbus_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dram_ck,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe,
  output logic       busy
);

  localparam logic [7:0] LAT_1X = 8'(2 * LATENCY);
  localparam logic [7:0] LAT_2X = 8'(4 * LATENCY);

  logic        ck_r, ck_d_r, rwds_r;
  logic [7:0]  dq_r;
  logic        edge_s, srst_s;

  hb_state_e   state_r;
  logic [2:0]  byte_cnt_r;
  logic [7:0]  lat_cnt_r;
  logic        is_read_r, is_reg_r, byte_sel_r;
  logic [31:0] addr_r;
  logic [15:0] cr0_r;
  logic [7:0]  wr_hi_r, rd_lo_r;
  logic        wr_hi_en_r;

  logic [7:0]  dq_out_r;
  logic        dq_oe_r, rwds_out_r, rwds_oe_r, busy_r;

  logic [15:0] mem_rdata_s, reg_rdata_s, rd_word_s, wr_word_s;
  logic [1:0]  wr_be_s;
  logic        mem_we_s;

  assign edge_s = ck_r ^ ck_d_r;
  assign srst_s = ~dram_rst_l;

  assign dram_dq_out   = dq_out_r;
  assign dram_dq_oe    = dq_oe_r;
  assign dram_rwds_out = rwds_out_r;
  assign dram_rwds_oe  = rwds_oe_r;
  assign busy          = busy_r;

  // Sample the bus pins once; ck is delayed again to find toggles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_r   <= 1'b0;
      ck_d_r <= 1'b0;
      dq_r   <= 8'h00;
      rwds_r <= 1'b0;
    end else begin
      ck_r   <= dram_ck;
      ck_d_r <= ck_r;
      dq_r   <= dram_dq_in;
      rwds_r <= dram_rwds_in;
    end
  end

  // Read word source: register space or RAM; write word and byte enables.
  always_comb begin
    if (addr_r == ID0_ADDR) begin
      reg_rdata_s = ID0_VAL;
    end else if (addr_r == CR0_ADDR) begin
      reg_rdata_s = cr0_r;
    end else begin
      reg_rdata_s = 16'h0000;
    end
    if (is_reg_r) begin
      rd_word_s = reg_rdata_s;
    end else begin
      rd_word_s = mem_rdata_s;
    end
    wr_word_s = {wr_hi_r, dq_r};
    // RWDS high masks the byte it accompanies.
    wr_be_s   = {wr_hi_en_r, ~rwds_r};
    // Commit on the second byte only while CS is still low, so an abort
    // coincident with that byte leaves memory untouched.
    mem_we_s  = ~srst_s & ~dram_cs_l & (state_r == ST_WDATA) & edge_s &
                byte_sel_r & ~is_reg_r;
  end

  hyperbus_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .addr  (addr_r[ADDR_W-1:0]),
    .we    (mem_we_s),
    .be    (wr_be_s),
    .wdata (wr_word_s),
    .rdata (mem_rdata_s)
  );

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cr0_r      <= CR0_RST;
      byte_cnt_r <= 3'd0;
      lat_cnt_r  <= 8'd0;
      is_read_r  <= 1'b0;
      is_reg_r   <= 1'b0;
      byte_sel_r <= 1'b0;
      addr_r     <= 32'd0;
      wr_hi_r    <= 8'h00;
      wr_hi_en_r <= 1'b0;
      rd_lo_r    <= 8'h00;
      dq_out_r   <= 8'h00;
      dq_oe_r    <= 1'b0;
      rwds_out_r <= 1'b0;
      rwds_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else if (srst_s) begin
      state_r    <= ST_IDLE;
      cr0_r      <= CR0_RST;
      byte_sel_r <= 1'b0;
      dq_out_r   <= 8'h00;
      dq_oe_r    <= 1'b0;
      rwds_out_r <= 1'b0;
      rwds_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else if (dram_cs_l) begin
      // Abort/idle path: any pending half-word is simply forgotten.
      state_r    <= ST_IDLE;
      byte_sel_r <= 1'b0;
      dq_out_r   <= 8'h00;
      dq_oe_r    <= 1'b0;
      rwds_out_r <= 1'b0;
      rwds_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_CA;
          byte_cnt_r <= 3'd0;
          byte_sel_r <= 1'b0;
          busy_r     <= 1'b1;
          dq_oe_r    <= 1'b0;
          rwds_oe_r  <= 1'b1;
          rwds_out_r <= cr0_r[CR0_LAT2X_BIT];
        end
        ST_CA: begin
          if (edge_s) begin
            byte_cnt_r <= byte_cnt_r + 3'd1;
            case (byte_cnt_r)
              3'd0: begin
                is_read_r    <= dq_r[CA_B0_RW_BIT];
                is_reg_r     <= dq_r[CA_B0_AS_BIT];
                addr_r[31:27] <= dq_r[CA_B0_ROW_MSB:0];
              end
              3'd1: addr_r[26:19] <= dq_r;
              3'd2: addr_r[18:11] <= dq_r;
              3'd3: addr_r[10:3]  <= dq_r;
              default: ;
            endcase
            if (byte_cnt_r == CA_LAST) begin
              addr_r[2:0] <= dq_r[2:0];
              byte_sel_r  <= 1'b0;
              if (!is_read_r && is_reg_r) begin
                // Register writes carry no latency.
                state_r    <= ST_WDATA;
                rwds_oe_r  <= 1'b0;
                rwds_out_r <= 1'b0;
              end else begin
                state_r   <= ST_LAT;
                lat_cnt_r <= cr0_r[CR0_LAT2X_BIT] ? LAT_2X : LAT_1X;
                if (!is_read_r) begin
                  rwds_oe_r  <= 1'b0;
                  rwds_out_r <= 1'b0;
                end
              end
            end
          end
        end
        ST_LAT: begin
          if (edge_s) begin
            lat_cnt_r <= lat_cnt_r - 8'd1;
            if (lat_cnt_r <= 8'd1) begin
              byte_sel_r <= 1'b0;
              if (is_read_r) begin
                // RWDS restarts low so the first data byte rises it.
                state_r    <= ST_RDATA;
                dq_oe_r    <= 1'b1;
                rwds_oe_r  <= 1'b1;
                rwds_out_r <= 1'b0;
              end else begin
                state_r <= ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (edge_s) begin
            if (!byte_sel_r) begin
              wr_hi_r    <= dq_r;
              wr_hi_en_r <= ~rwds_r;
              byte_sel_r <= 1'b1;
            end else begin
              if (is_reg_r && (addr_r == CR0_ADDR)) begin
                cr0_r <= merge_bytes(cr0_r, wr_word_s, wr_be_s);
              end
              addr_r     <= addr_r + 32'd1;
              byte_sel_r <= 1'b0;
            end
          end
        end
        ST_RDATA: begin
          dq_oe_r   <= 1'b1;
          rwds_oe_r <= 1'b1;
          if (edge_s) begin
            rwds_out_r <= ~rwds_out_r;
            if (!byte_sel_r) begin
              // Advancing the address here prefetches the next word.
              dq_out_r   <= rd_word_s[15:8];
              rd_lo_r    <= rd_word_s[7:0];
              addr_r     <= addr_r + 32'd1;
              byte_sel_r <= 1'b1;
            end else begin
              dq_out_r   <= rd_lo_r;
              byte_sel_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_responder.sv
// Directed bench for hyperbus_responder: drives the initiator side of the
// bus and checks returned bytes, strobes, latency and abort behaviour.
module tb_hyperbus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       dram_ck, dram_cs_l, dram_rst_l, dram_rwds_in;
  logic [7:0] dram_dq_in;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe, dram_rwds_out, dram_rwds_oe, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap_dq [8];
  logic       cap_rw [8];

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;   // {hi byte, lo byte}; 1 = masked
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [6];

  hyperbus_responder dut (
    .clk           (clk),
    .reset         (reset),
    .dram_ck       (dram_ck),
    .dram_cs_l     (dram_cs_l),
    .dram_rst_l    (dram_rst_l),
    .dram_dq_in    (dram_dq_in),
    .dram_dq_out   (dram_dq_out),
    .dram_dq_oe    (dram_dq_oe),
    .dram_rwds_in  (dram_rwds_in),
    .dram_rwds_out (dram_rwds_out),
    .dram_rwds_oe  (dram_rwds_oe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_val(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic [31:0] a);
    logic [47:0] ca;
    ca = 48'h0;
    ca[47] = rd;
    ca[46] = rg;
    ca[45] = 1'b1;
    ca[44:16] = a[31:3];
    ca[2:0] = a[2:0];
    return ca;
  endfunction

  // One CK toggle carrying a byte; returns at the sampling point 2 clk later.
  task automatic send_edge(input logic [7:0] b, input logic rw);
    dram_dq_in   = b;
    dram_rwds_in = rw;
    dram_ck      = ~dram_ck;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic begin_txn(input logic [47:0] ca, input logic exp_rw, input string nm);
    dram_cs_l = 1'b0;
    @(negedge clk);
    check_bit({nm, " ca rwds_oe"}, dram_rwds_oe, 1'b1);
    check_bit({nm, " ca rwds_out"}, dram_rwds_out, exp_rw);
    check_bit({nm, " ca busy"}, busy, 1'b1);
    for (int i = 0; i < 6; i++) send_edge(ca[8*(5-i) +: 8], 1'b0);
  endtask

  task automatic latency(input int n, input logic rd, input string nm);
    for (int i = 0; i < n; i++) begin
      send_edge(8'h00, 1'b0);
      if (!rd && i == 0) check_bit({nm, " lat rwds_oe"}, dram_rwds_oe, 1'b0);
      if (rd && i == n - 2) check_bit({nm, " lat-1 dq_oe"}, dram_dq_oe, 1'b0);
      if (rd && i == n - 1) check_bit({nm, " lat dq_oe"}, dram_dq_oe, 1'b1);
    end
  endtask

  task automatic end_txn(input string nm);
    dram_cs_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_bit({nm, " end busy"}, busy, 1'b0);
  endtask

  task automatic read_txn(input logic [31:0] a, input logic rg, input int nbytes,
                          input int lat, input logic exp_rw, input bit fast, input string nm);
    begin_txn(make_ca(1'b1, rg, a), exp_rw, nm);
    latency(lat, 1'b1, nm);
    if (!fast) begin
      for (int i = 0; i < nbytes; i++) begin
        send_edge(8'h00, 1'b0);
        cap_dq[i] = dram_dq_out;
        cap_rw[i] = dram_rwds_out;
      end
    end else begin
      for (int i = 0; i <= nbytes; i++) begin
        if (i < nbytes) dram_ck = ~dram_ck;
        @(negedge clk);
        if (i >= 1) begin
          cap_dq[i-1] = dram_dq_out;
          cap_rw[i-1] = dram_rwds_out;
        end
      end
    end
    end_txn(nm);
  endtask

  // exp holds the expected bytes left-aligned, first byte in [63:56].
  task automatic verify_read(input string nm, input int nbytes, input logic [63:0] exp);
    for (int i = 0; i < nbytes; i++) begin
      check_val($sformatf("%s byte%0d", nm, i), {8'h00, cap_dq[i]}, {8'h00, exp[63-8*i -: 8]});
      check_bit($sformatf("%s rwds%0d", nm, i), cap_rw[i], (i % 2) == 0);
    end
  endtask

  // words: word w in [16*w +: 16]; masks: word w in [2*w +: 2] as {hi, lo}.
  task automatic write_txn(input logic [31:0] a, input logic rg, input int nwords,
                           input logic [63:0] words, input logic [7:0] masks,
                           input int lat, input logic exp_rw, input string nm);
    begin_txn(make_ca(1'b0, rg, a), exp_rw, nm);
    if (rg) check_bit({nm, " reg rwds_oe"}, dram_rwds_oe, 1'b0);
    else latency(lat, 1'b0, nm);
    for (int w = 0; w < nwords; w++) begin
      send_edge(words[16*w+8 +: 8], masks[2*w+1]);
      send_edge(words[16*w +: 8], masks[2*w]);
    end
    end_txn(nm);
  endtask

  initial begin
    vecs[0] = '{32'd4, 16'h1234, 2'b01, 16'h12AD};
    vecs[1] = '{32'd5, 16'h5678, 2'b10, 16'hBE78};
    vecs[2] = '{32'd7, 16'h0F0F, 2'b00, 16'h0F0F};
    vecs[3] = '{32'd7, 16'hA55A, 2'b11, 16'h0F0F};
    vecs[4] = '{32'd9, 16'h00FF, 2'b00, 16'h00FF};
    vecs[5] = '{32'd9, 16'h7E00, 2'b01, 16'h7EFF};

    reset = 1'b1;
    dram_ck = 1'b0;
    dram_cs_l = 1'b1;
    dram_rst_l = 1'b1;
    dram_dq_in = 8'h00;
    dram_rwds_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset dq_oe", dram_dq_oe, 1'b0);
    check_bit("reset rwds_oe", dram_rwds_oe, 1'b0);
    check_bit("reset rwds_out", dram_rwds_out, 1'b0);
    check_val("reset dq_out", {8'h00, dram_dq_out}, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // ID0 register read, 2x latency from CR0 reset value.
    read_txn(32'd0, 1'b1, 2, 24, 1'b1, 1'b0, "id0");
    verify_read("id0", 2, 64'h0C81_0000_0000_0000);

    // Two-word burst write, fast two-word readback.
    write_txn(32'd4, 1'b0, 2, {32'h0, 16'hBEEF, 16'hDEAD}, 8'h00, 24, 1'b1, "wr4");
    read_txn(32'd4, 1'b0, 4, 24, 1'b1, 1'b1, "rd4");
    verify_read("rd4", 4, 64'hDEAD_BEEF_0000_0000);

    // Masked single-word writes from the table.
    for (int k = 0; k < 6; k++) begin
      write_txn(vecs[k].addr, 1'b0, 1, {48'h0, vecs[k].wdata}, {6'b0, vecs[k].mask},
                24, 1'b1, $sformatf("vw%0d", k));
      read_txn(vecs[k].addr, 1'b0, 2, 24, 1'b1, 1'b0, $sformatf("vr%0d", k));
      verify_read($sformatf("vec%0d", k), 2, {vecs[k].exp, 48'h0});
    end

    // CR0 write selecting 1x latency, then register and memory readback.
    write_txn(32'h800, 1'b1, 1, {48'h0, 16'h8F17}, 8'h00, 0, 1'b1, "cr0w");
    read_txn(32'h800, 1'b1, 2, 12, 1'b0, 1'b0, "cr0r");
    verify_read("cr0r", 2, 64'h8F17_0000_0000_0000);
    read_txn(32'd4, 1'b0, 2, 12, 1'b0, 1'b0, "rd4x1");
    verify_read("rd4x1", 2, 64'h12AD_0000_0000_0000);

    // Address wrap from the top of memory.
    write_txn(32'd1023, 1'b0, 3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 8'h00, 12, 1'b0, "wrap");
    read_txn(32'd1023, 1'b0, 6, 12, 1'b0, 1'b1, "wrapr");
    verify_read("wrapr", 6, 64'h1111_2222_3333_0000);
    read_txn(32'd1, 1'b0, 2, 12, 1'b0, 1'b0, "rd1");
    verify_read("rd1", 2, 64'h3333_0000_0000_0000);

    // Abort after byte 0 of a write word.
    write_txn(32'd8, 1'b0, 1, {48'h0, 16'hCAFE}, 8'h00, 12, 1'b0, "wr8");
    begin_txn(make_ca(1'b0, 1'b0, 32'd8), 1'b0, "ab1");
    latency(12, 1'b0, "ab1");
    send_edge(8'h99, 1'b0);
    dram_cs_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_bit("ab1 busy", busy, 1'b0);
    check_bit("ab1 dq_oe", dram_dq_oe, 1'b0);
    check_bit("ab1 rwds_oe", dram_rwds_oe, 1'b0);
    read_txn(32'd8, 1'b0, 2, 12, 1'b0, 1'b0, "ab1r");
    verify_read("ab1r", 2, 64'hCAFE_0000_0000_0000);

    // CS rises in the clk the responder sees the second byte's edge.
    begin_txn(make_ca(1'b0, 1'b0, 32'd8), 1'b0, "ab2");
    latency(12, 1'b0, "ab2");
    send_edge(8'h77, 1'b0);
    dram_dq_in = 8'h66;
    dram_ck = ~dram_ck;
    @(negedge clk);
    dram_cs_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_bit("ab2 busy", busy, 1'b0);
    read_txn(32'd8, 1'b0, 2, 12, 1'b0, 1'b0, "ab2r");
    verify_read("ab2r", 2, 64'hCAFE_0000_0000_0000);

    // Device reset in the middle of a read restores CR0.
    begin_txn(make_ca(1'b1, 1'b0, 32'd4), 1'b0, "rst");
    latency(12, 1'b1, "rst");
    send_edge(8'h00, 1'b0);
    check_val("rst first byte", {8'h00, dram_dq_out}, 16'h0012);
    dram_rst_l = 1'b0;
    @(negedge clk);
    check_bit("rst busy", busy, 1'b0);
    check_bit("rst dq_oe", dram_dq_oe, 1'b0);
    check_bit("rst rwds_oe", dram_rwds_oe, 1'b0);
    check_val("rst dq_out", {8'h00, dram_dq_out}, 16'h0000);
    dram_cs_l = 1'b1;
    @(negedge clk);
    dram_rst_l = 1'b1;
    @(negedge clk);
    @(negedge clk);
    read_txn(32'h800, 1'b1, 2, 24, 1'b1, 1'b0, "cr0rst");
    verify_read("cr0rst", 2, 64'h8F1F_0000_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_responder.md
Name: hyperbus_responder

Overview:
- Synthesizable HyperBus device-side responder.
- Answers the transactions issued by hyper_xface on the dram_* pins (CK, CS#, RST#, DQ, RWDS) and is backed by an internal 16-bit word memory plus a small register space.
- Used as an on-chip loopback target for hyper_xface when no HyperRAM is fitted, and as the device model in system benches.
- Runs on the same clk as hyper_xface; dram_ck is treated as a sampled strobe, not as a clock.

Parameters:
ADDR_W, 10, word address width; memory depth is 2^ADDR_W 16-bit words.
LATENCY, 6, initial latency in CK cycles (1x).
ID0_VAL, 16'h0C81, value returned for register-space reads of word address 0.
CR0_RST, 16'h8F1F, reset value of CR0; CR0[3]=1 selects fixed 2x latency.

Ports:
clk  in  1  system clock; same clock as hyper_xface.
reset  in  1  asynchronous, active-high reset.
dram_ck  in  1  HyperBus CK from the initiator.
dram_cs_l  in  1  chip select, active low.
dram_rst_l  in  1  device reset, active low; sampled synchronously.
dram_dq_in  in  8  DQ from the initiator.
dram_dq_out  out  8  DQ driven by the responder.
dram_dq_oe  out  1  DQ output enable, active high.
dram_rwds_in  in  1  RWDS from the initiator (write mask).
dram_rwds_out  out  1  RWDS driven by the responder.
dram_rwds_oe  out  1  RWDS output enable, active high.
busy  out  1  high while any state other than IDLE is active.

Behaviour:
- Edge detect: register dram_ck and dram_dq_in once (ck_s, dq_s), then delay ck_s once more (ck_d). edge = ck_s ^ ck_d. One edge equals one byte (DDR). The initiator toggles CK at most once per clk.
- Reset, or dram_rst_l low (synchronous): state=IDLE, CR0=CR0_RST, all outputs 0, oe low. Memory contents are not cleared.
- CS high in any state forces IDLE on the next clk: oe drops, any partial write word is discarded, and no memory update occurs. This is the abort path.
- IDLE: on CS low go to CA, byte count 0, dram_rwds_oe=1. dram_rwds_out is 1 when 2x latency applies (CR0[3]=1), else 0. It is held through CA and LAT.
- CA: shift 6 bytes MSB-first into CA[47:0].
  - CA[47]=read.
  - CA[46]=register space.
  - CA[45] (burst type) is ignored; bursts are always linear.
  - Word address = {CA[44:16], CA[2:0]} truncated to ADDR_W.
- After the 6th byte:
  - Register write: go directly to WDATA with zero latency and drop rwds_oe.
  - All other transactions: go to LAT with lat_cnt = 2*LATENCY*(CR0[3]?2:1) edges.
  - For writes, rwds_oe drops when LAT is entered.
- LAT: decrement lat_cnt on each edge. At 0, go to RDATA (read) or WDATA (write).
- WDATA:
  - Byte 0 goes to [15:8] and is written unless rwds_s=1. Byte 1 goes to [7:0] and is written unless rwds_s=1. rwds_s is sampled with dq.
  - On the second byte, commit the word to memory with per-byte enables, then increment the address.
  - The address wraps from 2^ADDR_W-1 to 0.
  - Register writes update CR0 only at word address 12'h800. Other register addresses are ignored.
- RDATA:
  - dram_dq_oe=1 and dram_rwds_oe=1 from entry.
  - One clk after each edge, drive the next byte on dram_dq_out ([15:8] first) and toggle dram_rwds_out in the same clk.
  - Memory read latency is 1 clk: fetch the next word on the first byte of the current word.
  - The address wraps as in WDATA.
  - Register reads return ID0_VAL at address 0, CR0 at 12'h800, and 0 elsewhere.
- Simultaneous CS rise and edge: CS wins and the byte is dropped.
- Edges while CS is high are ignored.
- Latency: from an edge to the corresponding dq_out/rwds_out change is 2 clk (sync plus output register).

Decomposition:
- Shared package hyperbus_pkg holds:
  - state encoding IDLE/CA/LAT/WDATA/RDATA;
  - CA field bit positions;
  - CR0 word address 12'h800 and ID0 address 0;
  - CA byte count 6.
- One natural sub-module: hyperbus_resp_mem, a 2^ADDR_W x 16 single-port RAM with 2 byte enables and registered read. It infers iCE40 block RAM.

Test Plan:
- Reset, then register read of addr 0 -> rwds_oe high during CA with rwds_out=1 (CR0 reset fixed 2x). First data appears after 24 latency edges. Bytes read 8'h0C, 8'h81, with rwds_out toggling each byte.
- Memory write of 32'hDEADBEEF at word addr 4 with RWDS=0 throughout, then read 2 words at addr 4 -> 8'hDE,8'hAD,8'hBE,8'hEF.
- Masked write of 16'h1234 to addr 4 with RWDS=1 on the second byte -> readback 8'h12,8'hAD.
- Register write of 16'h8F17 to 12'h800 (CR0[3]=0) -> the following memory read shows rwds_out=0 during CA and latency of 12 edges, and returns the correct data.
- Write 3 words starting at addr 2^ADDR_W-1 -> words land at 1023, 0, 1; readback from 1023 confirms the wrap.
- CS deasserted after byte 0 of a write word -> the memory word is unchanged and busy=0 and all oe=0 within 2 clk. Asserting dram_rst_l low mid-read -> CR0 returns to 16'h8F1F.
